// File: rtl/seq_mult_display.sv
// Sequential shift-add multiplier with a multiplexed hex seven-segment scan.
// The shown value is snapshotted at frame start so a frame never tears.
module seq_mult_display #(
   parameter  int WIDTH   = 4,
   parameter  int REFRESH = 1250,
   localparam int DIGITS  = (2*WIDTH+3)/4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [WIDTH-1:0]   i_factor_a,
   input  logic [WIDTH-1:0]   i_factor_b,
   input  logic               i_start,
   output logic               o_busy,
   output logic               o_done,
   output logic [2*WIDTH-1:0] o_product,
   output logic [6:0]         o_segments,
   output logic [DIGITS-1:0]  o_digit_sel
);

   localparam int PW = 2*WIDTH;
   localparam int NW = 4*DIGITS;
   localparam int IW = $clog2(WIDTH);
   localparam int RW = (REFRESH > 1) ? $clog2(REFRESH) : 1;
   localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t         state_q, state_d;
   logic [PW-1:0]  a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [PW-1:0]  acc_q, acc_d;
   logic [IW-1:0]  iter_q, iter_d;
   logic [PW-1:0]  prod_q, prod_d;
   logic           done_q, done_d;

   logic [RW-1:0]  ref_q, ref_d;
   logic [DW-1:0]  idx_q, idx_d;
   logic [PW-1:0]  snap_q, snap_d;
   logic [NW-1:0]  snap_pad;
   logic [3:0]     nib;
   logic           ref_wrap;
   logic           frame_wrap;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         iter_q  <= '0;
         prod_q  <= '0;
         done_q  <= 1'b0;
         ref_q   <= '0;
         idx_q   <= '0;
         snap_q  <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         iter_q  <= iter_d;
         prod_q  <= prod_d;
         done_q  <= done_d;
         ref_q   <= ref_d;
         idx_q   <= idx_d;
         snap_q  <= snap_d;
      end
   end

   // a_q is pre-shifted each step, so it always equals factor_a << iter
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      iter_d  = iter_q;
      prod_d  = prod_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (i_start) begin
               a_d     = PW'(i_factor_a);
               b_d     = i_factor_b;
               acc_d   = '0;
               iter_d  = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d  = acc_q + (b_q[0] ? a_q : '0);
            a_d    = a_q << 1;
            b_d    = b_q >> 1;
            iter_d = iter_q + IW'(1);
            if (iter_q == IW'(WIDTH-1)) begin
               prod_d  = acc_d;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign ref_wrap   = (ref_q == RW'(REFRESH-1));
   assign frame_wrap = ref_wrap && (idx_q == DW'(DIGITS-1));

   always_comb begin
      ref_d  = ref_wrap ? '0 : ref_q + RW'(1);
      idx_d  = idx_q;
      snap_d = snap_q;
      if (ref_wrap) begin
         idx_d = frame_wrap ? '0 : idx_q + DW'(1);
      end
      if (frame_wrap) begin
         snap_d = prod_q;
      end
   end

   assign snap_pad = NW'(snap_q);
   assign nib      = 4'(snap_pad >> {idx_q, 2'b00});

   always_comb begin
      o_segments = 7'h00;
      unique case (nib)
         4'h0: o_segments = 7'h3F;
         4'h1: o_segments = 7'h06;
         4'h2: o_segments = 7'h5B;
         4'h3: o_segments = 7'h4F;
         4'h4: o_segments = 7'h66;
         4'h5: o_segments = 7'h6D;
         4'h6: o_segments = 7'h7D;
         4'h7: o_segments = 7'h07;
         4'h8: o_segments = 7'h7F;
         4'h9: o_segments = 7'h6F;
         4'hA: o_segments = 7'h77;
         4'hB: o_segments = 7'h7C;
         4'hC: o_segments = 7'h39;
         4'hD: o_segments = 7'h5E;
         4'hE: o_segments = 7'h79;
         4'hF: o_segments = 7'h71;
      endcase
   end

   assign o_digit_sel = DIGITS'(1) << idx_q;
   assign o_busy      = (state_q == RUN);
   assign o_done      = done_q;
   assign o_product   = prod_q;

endmodule

// File: tb/tb_seq_mult_display.sv
// Bench for seq_mult_display: two configurations, a cycle model and
// directed checks of products, handshake timing and the display scan.
module tb_seq_mult_display;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst0, rst1, start0, start1;
   logic [3:0] a0, b0;
   logic [7:0] a1, b1;
   logic       busy0, done0, busy1, done1;
   logic [7:0] prod0;
   logic [15:0] prod1;
   logic [6:0] seg0, seg1;
   logic [1:0] sel0;
   logic [3:0] sel1;

   seq_mult_display #(.WIDTH(4), .REFRESH(4)) u0 (
      .clk(clk), .reset(rst0),
      .i_factor_a(a0), .i_factor_b(b0), .i_start(start0),
      .o_busy(busy0), .o_done(done0), .o_product(prod0),
      .o_segments(seg0), .o_digit_sel(sel0)
   );

   seq_mult_display #(.WIDTH(8), .REFRESH(3)) u1 (
      .clk(clk), .reset(rst1),
      .i_factor_a(a1), .i_factor_b(b1), .i_start(start1),
      .o_busy(busy1), .o_done(done1), .o_product(prod1),
      .o_segments(seg1), .o_digit_sel(sel1)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Model: ops finish W cycles after acceptance; digit index follows
   // the cycle count since reset; snapshot is taken at each frame start.
   int W[2] = '{4, 8};
   int R[2] = '{4, 3};
   int D[2] = '{2, 4};
   int rem[2], pend[2], prod[2], n[2], snap[2];
   bit mdone[2];
   bit armed[2] = '{1'b0, 1'b0};
   logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F,
                                7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C,
                                7'h39, 7'h5E, 7'h79, 7'h71};

   task automatic step(int k, bit r, bit s, int a, int b);
      int io, inew;
      if (r) begin
         rem[k] = 0; pend[k] = 0; prod[k] = 0;
         mdone[k] = 0; n[k] = 0; snap[k] = 0;
         armed[k] = 1;
      end else begin
         io = (n[k] / R[k]) % D[k];
         n[k]++;
         inew = (n[k] / R[k]) % D[k];
         if (io == D[k] - 1 && inew == 0) snap[k] = prod[k];
         mdone[k] = 0;
         if (rem[k] > 0) begin
            rem[k]--;
            if (rem[k] == 0) begin
               prod[k] = pend[k];
               mdone[k] = 1;
            end
         end else if (s) begin
            pend[k] = a * b;
            rem[k] = W[k];
         end
      end
   endtask

   always @(posedge clk) begin
      step(0, rst0, start0, int'(a0), int'(b0));
      step(1, rst1, start1, int'(a1), int'(b1));
   end

   task automatic cmp(int k, int bz, int dn, int pr, int sl, int sg);
      int i;
      i = (n[k] / R[k]) % D[k];
      chk($sformatf("busy%0d", k), bz, int'(rem[k] > 0));
      chk($sformatf("done%0d", k), dn, int'(mdone[k]));
      chk($sformatf("prod%0d", k), pr, prod[k]);
      chk($sformatf("sel%0d", k), sl, 1 << i);
      chk($sformatf("seg%0d", k), sg,
          int'(seg_tab[(snap[k] >> (4*i)) & 15]));
   endtask

   always @(negedge clk) begin
      if (armed[0]) cmp(0, busy0, done0, prod0, sel0, seg0);
      if (armed[1]) cmp(1, busy1, done1, prod1, sel1, seg1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(int k, output int cyc);
      cyc = 0;
      while (((k == 0) ? done0 : done1) == 1'b0 && cyc < 40) begin
         tick();
         cyc++;
      end
      if (cyc >= 40) chk($sformatf("done%0d_timeout", k), 0, 1);
   endtask

   task automatic wait_frame0();
      logic [1:0] pv;
      int g;
      pv = sel0;
      g = 0;
      while (g < 40) begin
         tick();
         g++;
         if (sel0 == 2'b01 && pv == 2'b10) break;
         pv = sel0;
      end
      if (g >= 40) chk("frame0_timeout", 0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int cyc, pn, g;
      logic [3:0] pv;
      int p4[3] = '{8'h0F, 8'h3C, 8'h37};
      int d6[4] = '{7'h06, 7'h3F, 7'h79, 7'h71};

      rst0 = 1; rst1 = 1; start0 = 0; start1 = 0;
      a0 = 0; b0 = 0; a1 = 0; b1 = 0;
      tick(); tick();
      rst0 = 0; rst1 = 0;

      // 1: reset state and first digit advance
      chk("t1_busy", busy0, 0);
      chk("t1_done", done0, 0);
      chk("t1_prod", prod0, 0);
      chk("t1_sel", sel0, 2'b01);
      chk("t1_seg", seg0, 7'h3F);
      repeat (4) tick();
      chk("t1_sel_adv", sel0, 2'b10);

      // 2: 7*6 and its display in the following frame
      a0 = 7; b0 = 6; start0 = 1;
      tick();
      start0 = 0;
      chk("t2_busy", busy0, 1);
      wait_done(0, cyc);
      chk("t2_lat", cyc, 4);
      chk("t2_prod", prod0, 8'h2A);
      wait_frame0();
      chk("t2_sel_lo", sel0, 2'b01);
      chk("t2_seg_lo", seg0, 7'h77);
      repeat (4) tick();
      chk("t2_sel_hi", sel0, 2'b10);
      chk("t2_seg_hi", seg0, 7'h5B);

      // 3: 15*15, then a zero factor
      a0 = 15; b0 = 15; start0 = 1;
      tick();
      start0 = 0;
      wait_done(0, cyc);
      chk("t3_prod_ff", prod0, 8'hE1);
      a0 = 0; b0 = 9; start0 = 1;
      tick();
      start0 = 0;
      wait_done(0, cyc);
      chk("t3_lat0", cyc, 4);
      chk("t3_done0", done0, 1);
      chk("t3_prod0", prod0, 0);

      // 4: start held high with factors changing every cycle
      pn = 0;
      start0 = 1;
      for (int i = 0; i < 15; i++) begin
         a0 = 4'(i + 1);
         b0 = 4'(15 - i);
         tick();
         if (done0) begin
            if (pn < 3) chk($sformatf("t4_prod%0d", pn), prod0, p4[pn]);
            pn++;
         end
      end
      start0 = 0;
      chk("t4_count", pn, 3);

      // 5: reset in the second RUN cycle
      a0 = 5; b0 = 3; start0 = 1;
      tick();
      start0 = 0;
      tick();
      rst0 = 1;
      tick();
      rst0 = 0;
      chk("t5_busy", busy0, 0);
      chk("t5_prod", prod0, 0);
      chk("t5_done", done0, 0);
      chk("t5_sel", sel0, 2'b01);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("t5_nodone", done0, 0);
      end

      // 6: WIDTH=8, 255*255, held display until next frame
      a1 = 255; b1 = 255; start1 = 1;
      tick();
      start1 = 0;
      wait_done(1, cyc);
      chk("t6_lat", cyc, 8);
      chk("t6_prod", prod1, 16'hFE01);
      pv = sel1;
      g = 0;
      while (g < 40) begin
         chk("t6_hold", seg1, 7'h3F);
         tick();
         g++;
         if (sel1 == 4'd1 && pv == 4'd8) break;
         pv = sel1;
      end
      if (g >= 40) chk("frame1_timeout", 0, 1);
      for (int d = 0; d < 4; d++) begin
         chk($sformatf("t6_sel%0d", d), sel1, 1 << d);
         chk($sformatf("t6_seg%0d", d), seg1, d6[d]);
         repeat (3) tick();
      end
      chk("t6_sel_wrap", sel1, 4'd1);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
